// File: rtl/suspend_sync_ctrl.sv
// rtl/suspend_sync_ctrl.sv - multi-channel suspend request/acknowledge handshake controller
// Optional REQ-state timeout is enabled by defining SUSPEND_SYNC_TIMEOUT_EN.
module suspend_sync_ctrl #(
    parameter int NCH            = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TIMEOUT_W      = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           suspend_in,
    input  logic [NCH-1:0] ch_en,
    input  logic [NCH-1:0] sack,
    output logic [NCH-1:0] sreq,
    output logic           suspend_ok,
    output logic           wake_done,
    output logic           timeout_err,
    output logic [1:0]     state
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_SUSP    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    if (NCH < 1 || NCH > 16 || SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
        TIMEOUT_CYCLES < 2 || TIMEOUT_W < 1 ||
        ((TIMEOUT_CYCLES - 1) >> TIMEOUT_W) != 0) begin : g_bad_params
        $error("suspend_sync_ctrl: parameter out of range");
    end

    logic [SYNC_STAGES-1:0][NCH-1:0] sync_q;
    logic [NCH-1:0]                  sack_s;
    logic [NCH-1:0]                  mask;
    logic [NCH-1:0]                  mask_nx;
    logic [1:0]                      state_nx;
    logic                            all_ack;
    logic                            none_ack;
    logic                            timeout_hit;

    // Plain flop chain: the acknowledges come from other clock domains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sack};
        end
    end

    assign sack_s   = sync_q[SYNC_STAGES-1];
    assign all_ack  = (sack_s & mask) == mask;
    assign none_ack = (sack_s & mask) == '0;

    // Request withdrawal beats timeout, timeout beats a completing acknowledge.
    always_comb begin
        state_nx = state;
        mask_nx  = mask;
        case (state)
            ST_IDLE: begin
                if (suspend_in && (ch_en != '0)) begin
                    state_nx = ST_REQ;
                    mask_nx  = ch_en;
                end
            end
            ST_REQ: begin
                if (!suspend_in || timeout_hit) begin
                    state_nx = ST_RELEASE;
                end else if (all_ack) begin
                    state_nx = ST_SUSP;
                end
            end
            ST_SUSP: begin
                if (!suspend_in) begin
                    state_nx = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (none_ack) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with STATE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            mask       <= '0;
            sreq       <= '0;
            suspend_ok <= 1'b0;
            wake_done  <= 1'b0;
        end else begin
            state      <= state_nx;
            mask       <= mask_nx;
            sreq       <= (state_nx == ST_REQ || state_nx == ST_SUSP) ? mask_nx : '0;
            suspend_ok <= (state_nx == ST_SUSP);
            wake_done  <= (state == ST_RELEASE) && (state_nx == ST_IDLE);
        end
    end

`ifdef SUSPEND_SYNC_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] to_cnt;

    assign timeout_hit = (state == ST_REQ) && (to_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt      <= '0;
            timeout_err <= 1'b0;
        end else if (state == ST_IDLE && state_nx == ST_REQ) begin
            to_cnt      <= '0;
            timeout_err <= 1'b0;
        end else if (state == ST_REQ) begin
            to_cnt <= to_cnt + 1'b1;
            if (suspend_in && timeout_hit) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule
